// File: rtl/om_serial_mult.sv
// Radix-2 online multiplier: MSD-first signed-digit operands in, product digits out after 3 steps.
// Also accumulates the emitted digits into a parallel two's-complement result.
module om_serial_mult #(
  parameter int N     = 8,
  parameter int DELTA = 3
) (
  input  logic         clk,
  input  logic         Reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   in_x,
  input  logic [1:0]   in_y,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [1:0]   out_z,
  output logic         out_last,
  output logic [N+1:0] res_z,
  output logic         busy
);
  localparam int FW = N + 3;
  localparam int WW = N + 6;
  localparam int CW = $clog2(N + 3);
  localparam logic [CW-1:0]        CNT_LAST  = CW'(N + 2);
  localparam logic [CW-1:0]        CNT_RUN   = CW'(DELTA);
  localparam logic [CW-1:0]        CNT_FLUSH = CW'(N);
  localparam logic [CW-1:0]        CNT_ONE   = CW'(1);
  localparam logic signed [WW-1:0] VH_POS    = WW'(2);
  localparam logic signed [WW-1:0] VH_NEG    = WW'(-2);
  localparam logic signed [WW-1:0] ONE_W     = WW'(1);
  localparam logic signed [N+1:0]  ONE_N     = (N+2)'(1);

  typedef enum logic [1:0] {IDLE = 2'd0, INIT = 2'd1, RUN = 2'd2, FLUSH = 2'd3} state_t;

  // Internal digit form is a 2-bit two's-complement value: 01=+1, 11=-1, 00=0.
  function automatic logic [1:0] dig_dec(input logic [1:0] d);
    case (d)
      2'b10:   dig_dec = 2'b01;
      2'b01:   dig_dec = 2'b11;
      default: dig_dec = 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] dig_enc(input logic [1:0] s);
    case (s)
      2'b01:   dig_enc = 2'b10;
      2'b11:   dig_enc = 2'b01;
      default: dig_enc = 2'b00;
    endcase
  endfunction

  function automatic logic signed [WW-1:0] mul_w(input logic [1:0] s, input logic signed [WW-1:0] a);
    case (s)
      2'b01:   mul_w = a;
      2'b11:   mul_w = -a;
      default: mul_w = '0;
    endcase
  endfunction

  function automatic logic signed [N+1:0] mul_n(input logic [1:0] s, input logic signed [N+1:0] a);
    case (s)
      2'b01:   mul_n = a;
      2'b11:   mul_n = -a;
      default: mul_n = '0;
    endcase
  endfunction

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic signed [N+1:0]    x_q, y_q, res_q;
  logic signed [WW-1:0]   w_q;
  logic                   out_valid_q, out_last_q;
  logic [1:0]             out_z_q;

  logic                   stall_s, step_s;
  logic [1:0]             xd_s, yd_s, zd_s;
  logic signed [N+1:0]    xb_s, yb_s, rb_s, unit_s, xn_s, yn_s, rn_s;
  logic signed [WW-1:0]   wb_s, xe_s, yne_s, v_s, vh_s, wn_s;

  // Handshake, one recurrence step and next-state selection.
  always_comb begin
    stall_s  = out_valid_q & ~out_ready;
    in_ready = (state_q != FLUSH) & ~stall_s;
    if (state_q == FLUSH) begin
      step_s = ~stall_s;
      xd_s   = 2'b00;
      yd_s   = 2'b00;
    end else begin
      step_s = in_valid & in_ready;
      xd_s   = dig_dec(in_x);
      yd_s   = dig_dec(in_y);
    end
    // A fresh operation starts from a cleared datapath.
    if (state_q == IDLE) begin
      xb_s = '0;
      yb_s = '0;
      wb_s = '0;
      rb_s = '0;
    end else begin
      xb_s = x_q;
      yb_s = y_q;
      wb_s = w_q;
      rb_s = res_q;
    end
    if (cnt_q < CNT_FLUSH) begin
      unit_s = ONE_N <<< (N - 1 - int'(cnt_q));
    end else begin
      unit_s = '0;
    end
    xn_s  = xb_s + mul_n(xd_s, unit_s);
    yn_s  = yb_s + mul_n(yd_s, unit_s);
    xe_s  = {{(WW-N-2){xb_s[N+1]}}, xb_s};
    yne_s = {{(WW-N-2){yn_s[N+1]}}, yn_s};
    v_s   = (wb_s <<< 1) + mul_w(xd_s, yne_s) + mul_w(yd_s, xe_s);
    vh_s  = v_s >>> (N + 1);
    if (cnt_q >= CNT_RUN) begin
      if (vh_s >= VH_POS) begin
        zd_s = 2'b01;
      end else if (vh_s < VH_NEG) begin
        zd_s = 2'b11;
      end else begin
        zd_s = 2'b00;
      end
    end else begin
      zd_s = 2'b00;
    end
    wn_s  = v_s - mul_w(zd_s, ONE_W <<< FW);
    rn_s  = rb_s + mul_n(zd_s, ONE_N <<< (N + 2 - int'(cnt_q)));
    cnt_d = cnt_q + CNT_ONE;
    if (cnt_q == CNT_LAST) begin
      cnt_d   = '0;
      state_d = IDLE;
    end else if (cnt_d >= CNT_FLUSH) begin
      state_d = FLUSH;
    end else if (cnt_d >= CNT_RUN) begin
      state_d = RUN;
    end else begin
      state_d = INIT;
    end
  end

  // State, datapath and registered output digit.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      w_q         <= '0;
      res_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_z_q     <= 2'b00;
    end else if (step_s) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= xn_s;
      y_q     <= yn_s;
      w_q     <= wn_s;
      res_q   <= rn_s;
      if (cnt_q >= CNT_RUN) begin
        out_valid_q <= 1'b1;
        out_z_q     <= dig_enc(zd_s);
        out_last_q  <= (cnt_q == CNT_LAST);
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_z     = out_z_q;
  assign out_last  = out_last_q;
  assign res_z     = res_q;
  assign busy      = (state_q != IDLE);
endmodule

// File: tb/tb_om_serial_mult.sv
// Directed and randomized bench for om_serial_mult (N=8); values checked, not digit patterns.
module tb_om_serial_mult;
  logic       clk = 1'b0;
  logic       Reset, in_valid, in_ready, out_valid, out_ready, out_last, busy;
  logic [1:0] in_x, in_y, out_z;
  logic [9:0] res_z;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  om_serial_mult #(.N(8)) dut (
    .clk(clk), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .out_valid(out_valid), .out_ready(out_ready),
    .out_z(out_z), .out_last(out_last), .res_z(res_z), .busy(busy)
  );

  typedef struct {
    string name;
    string xs;
    string ys;
    int    prod;
    int    tol;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int dval(input logic [1:0] d);
    case (d)
      2'b10:   return 1;
      2'b01:   return -1;
      default: return 0;
    endcase
  endfunction

  function automatic logic [7:0][1:0] dg(input string s);
    logic [7:0][1:0] r;
    for (int i = 0; i < 8; i++) begin
      case (s[i])
        "+":     r[i] = 2'b10;
        "-":     r[i] = 2'b01;
        "x":     r[i] = 2'b11;
        default: r[i] = 2'b00;
      endcase
    end
    return r;
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic run_op(input string tag, input logic [7:0][1:0] xs, input logic [7:0][1:0] ys,
                        input int stall_at, input int stall_len, output int res);
    int idx = 0, ndig = 0, cyc = 0, acc4 = -100, first = -1, dsum = 0, rem, lastbad = 0;
    logic [1:0] held = 2'b00;
    rem = stall_len;
    res = 0;
    while (ndig < 8 && cyc < 300) begin
      @(negedge clk);
      in_valid = (idx < 8);
      if (idx < 8) begin
        in_x = xs[idx];
        in_y = ys[idx];
      end else begin
        in_x = 2'b00;
        in_y = 2'b00;
      end
      out_ready = !(ndig == stall_at && rem > 0);
      #1;
      if (out_valid && first < 0) first = cyc;
      if (!out_ready) begin
        if (rem == stall_len) held = out_z;
        else chk({tag, " stall out_z"}, int'(out_z), int'(held));
        chk({tag, " stall in_ready"}, int'(in_ready), 0);
        chk({tag, " stall out_valid"}, int'(out_valid), 1);
        rem--;
      end
      if (out_valid && out_ready) begin
        ndig++;
        dsum += dval(out_z) * (1 << (8 - ndig));
        if (out_last != (ndig == 8)) lastbad = 1;
        if (ndig == 8) res = int'($signed(res_z));
      end
      if (in_valid && in_ready) begin
        idx++;
        if (idx == 4) acc4 = cyc;
      end
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk({tag, " digit count"}, ndig, 8);
    chk({tag, " out_last placement"}, lastbad, 0);
    chk({tag, " first digit latency"}, first - acc4, 1);
    chk({tag, " digit sum vs res_z"}, dsum, res);
    @(negedge clk);
    #1;
    chk({tag, " busy after"}, int'(busy), 0);
    chk({tag, " out_valid after"}, int'(out_valid), 0);
  endtask

  initial begin
    int res, idx, cyc, pairs, k, xa, ya, dcnt;
    int q_exp[$];

    vecs[0] = '{"x.5*y.5",   "+0000000", "+0000000",  16384, 0};
    vecs[1] = '{"all_plus",  "++++++++", "++++++++",  65025, 1};
    vecs[2] = '{"neg_half",  "-0000000", "++000000", -24576, 0};
    vecs[3] = '{"q_by_-h",   "0+000000", "-0000000",  -8192, 1};
    vecs[4] = '{"redund",    "+-000000", "00+00000",   2048, 1};
    vecs[5] = '{"code11",    "x+000000", "0000000+",     64, 1};
    vecs[6] = '{"min_max",   "--------", "++++++++", -65025, 1};
    vecs[7] = '{"zero_x",    "00000000", "+-+-+-+-",      0, 0};
    vecs[8] = '{"mixed",     "+0-0+0-0", "0-0+0-0+",  -5202, 1};

    Reset = 1'b1; in_valid = 1'b0; in_x = 2'b00; in_y = 2'b00; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("reset out_valid", int'(out_valid), 0);
    chk("reset out_z", int'(out_z), 0);
    chk("reset out_last", int'(out_last), 0);
    chk("reset res_z", int'(res_z), 0);
    chk("reset busy", int'(busy), 0);
    Reset = 1'b0;
    @(negedge clk);
    #1;
    chk("post-reset in_ready", int'(in_ready), 1);

    for (int v = 0; v < 9; v++) begin
      run_op(vecs[v].name, dg(vecs[v].xs), dg(vecs[v].ys), -1, 0, res);
      if (vecs[v].tol == 0) chk({vecs[v].name, " res_z exact"}, res * 256, vecs[v].prod);
      else chk({vecs[v].name, " res_z within 2^-8"}, int'(iabs(res * 256 - vecs[v].prod) <= 256), 1);
    end

    // Back-pressure for five cycles after the third digit.
    run_op("stall", dg("+0000000"), dg("+0000000"), 3, 5, res);
    chk("stall res_z", res, 64);

    // Reset in the middle of an operation (step j=2), then a clean operation.
    idx = 0;
    cyc = 0;
    while (idx < 6 && cyc < 50) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_x = (idx == 0) ? 2'b10 : 2'b00;
      in_y = (idx == 0) ? 2'b10 : 2'b00;
      #1;
      if (in_ready) idx++;
      cyc++;
    end
    chk("midreset pairs accepted", idx, 6);
    @(negedge clk);
    in_valid = 1'b0;
    Reset = 1'b1;
    @(negedge clk);
    Reset = 1'b0;
    #1;
    chk("midreset out_valid", int'(out_valid), 0);
    chk("midreset in_ready", int'(in_ready), 1);
    chk("midreset busy", int'(busy), 0);
    repeat (3) @(negedge clk);
    #1;
    chk("midreset no stray digit", int'(out_valid), 0);
    run_op("after_reset", dg("-0000000"), dg("++000000"), -1, 0, res);
    chk("after_reset res_z", res, -96);

    // Random stream with back-pressure and injected 11 codes.
    pairs = 0; k = 0; xa = 0; ya = 0; dcnt = 0; cyc = 0;
    while ((pairs < 10000 || q_exp.size() > 0) && cyc < 80000) begin
      @(negedge clk);
      in_valid  = (pairs < 10000);
      in_x      = 2'($urandom_range(0, 3));
      in_y      = 2'($urandom_range(0, 3));
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (out_valid && out_ready) begin
        dcnt++;
        if (out_last) begin
          chk("random digits per op", dcnt, 8);
          dcnt = 0;
          if (q_exp.size() == 0) begin
            chk("random unexpected result", 0, 1);
          end else begin
            int p;
            p = q_exp.pop_front();
            chk("random res_z within 2^-8", int'(iabs(int'($signed(res_z)) * 256 - p) <= 256), 1);
          end
        end
      end
      if (in_valid && in_ready) begin
        xa += dval(in_x) * (1 << (7 - k));
        ya += dval(in_y) * (1 << (7 - k));
        k++;
        pairs++;
        if (k == 8) begin
          q_exp.push_back(xa * ya);
          k = 0; xa = 0; ya = 0;
        end
      end
      cyc++;
    end
    chk("random stream completed", int'(cyc < 80000), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
